// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte-wide transmit buffer between the CPU store path and the UART
// transmitter. Stores are pushed into a circular FIFO. A launch FSM pops one
// byte at a time, presents it on tx_data with a one-cycle send_tx pulse, and
// then follows the transmitter's busy handshake before launching the next byte.
//
// Optional feature macro: UART_TX_FIFO_TIMEOUT_EN
//   defined   : WAIT_BUSY gives up after BUSY_TIMEOUT cycles without
//               uart_busy rising, sets the sticky timeout_err flag and returns
//               to IDLE. The byte counts as sent and is not retried.
//   undefined : WAIT_BUSY waits forever and timeout_err is tied low.
//
// Every output comes straight from a register, so there is no combinational
// path from wr_en or uart_busy to any output.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2   = 3,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  clr_overflow,
    input  logic                  uart_busy,
    output logic                  send_tx,
    output logic [7:0]            tx_data,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic                  timeout_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    // Reject parameter values outside the supported range at elaboration.
    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 6) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH_LOG2 must be in 1..6");
    end
    if (BUSY_TIMEOUT < 2 || BUSY_TIMEOUT > 255) begin : g_bad_timeout
        $error("uart_tx_fifo: BUSY_TIMEOUT must be in 2..255");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                  state_q;
    logic [7:0]              mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q;
    logic [DEPTH_LOG2:0]     count_q;
    logic [DEPTH_LOG2:0]     count_d;
    logic                    empty_q;
    logic                    full_q;
    logic                    overflow_q;
    logic                    overflow_d;
    logic                    send_tx_q;
    logic [7:0]              tx_data_q;

    logic                    pop;
    logic                    push_ok;
    logic                    drop;

    // The only pop point is the IDLE->LAUNCH transition.
    assign pop     = (state_q == IDLE) && !empty_q && !uart_busy;
    // A push into a full FIFO still fits when the same edge frees a slot.
    assign push_ok = wr_en && (!full_q || pop);
    assign drop    = wr_en && !push_ok;

    // Next occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Sticky overflow: a new drop wins over a clear in the same cycle.
    always_comb begin
        overflow_d = (overflow_q && !clr_overflow) || drop;
    end

    // Storage array; contents past the read pointer are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers, occupancy counter and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == FULL_CNT);
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_TX_FIFO_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;
    logic       timeout_err_q;
`endif

    // Launch FSM: pop a byte, pulse send_tx, then follow the busy handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            send_tx_q     <= 1'b0;
            tx_data_q     <= 8'h00;
`ifdef UART_TX_FIFO_TIMEOUT_EN
            tmo_cnt_q     <= 8'd0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            send_tx_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        // tx_data only ever changes on the edge entering LAUNCH.
                        tx_data_q <= mem_q[rd_ptr_q];
                        send_tx_q <= 1'b1;
                        state_q   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state_q   <= WAIT_BUSY;
`ifdef UART_TX_FIFO_TIMEOUT_EN
                    tmo_cnt_q <= 8'd0;
`endif
                end
                WAIT_BUSY: begin
                    if (uart_busy) begin
                        state_q <= WAIT_DONE;
                    end
`ifdef UART_TX_FIFO_TIMEOUT_EN
                    else if (tmo_cnt_q == 8'(BUSY_TIMEOUT - 1)) begin
                        // Transmitter never acknowledged; drop the byte and move on.
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!uart_busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef UART_TX_FIFO_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign send_tx    = send_tx_q;
    assign tx_data    = tx_data_q;
    assign fifo_count = count_q;
    assign fifo_empty = empty_q;
    assign fifo_full  = full_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH_LOG2=3, BUSY_TIMEOUT=16).
// Inputs are driven and outputs sampled on the falling edge; an input set at
// the falling edge of cycle c is the value the DUT samples at the end of c.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_overflow = 1'b0;
    logic       uart_busy = 1'b0;
    logic       send_tx;
    logic [7:0] tx_data;
    logic [3:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overflow;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(.DEPTH_LOG2(3), .BUSY_TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .clr_overflow (clr_overflow),
        .uart_busy    (uart_busy),
        .send_tx      (send_tx),
        .tx_data      (tx_data),
        .fifo_count   (fifo_count),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .overflow     (overflow),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_overflow = 1'b0; uart_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({send_tx, tx_data, fifo_count, fifo_empty, fifo_full, overflow, timeout_err} !== {1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: send=%b data=%h cnt=%0d empty=%b full=%b ovf=%b tmo=%b, want 0 00 0 1 0 0 0",
                     send_tx, tx_data, fifo_count, fifo_empty, fifo_full, overflow, timeout_err);
        end
    endtask

    task automatic test_single_byte();
        do_reset();
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;      // cycle N
        @(negedge clk); wr_en = 1'b0;                        // cycle N+1
        checks++;
        if (fifo_count !== 4'd1 || fifo_empty !== 1'b0 || send_tx !== 1'b0) begin
            errors++;
            $display("FAIL single_queued: cnt=%0d empty=%b send=%b, want 1 0 0", fifo_count, fifo_empty, send_tx);
        end
        @(negedge clk);                                      // cycle N+2
        checks++;
        if (send_tx !== 1'b1 || tx_data !== 8'hA5 || fifo_count !== 4'd0 || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL single_launch: send=%b data=%h cnt=%0d empty=%b, want 1 a5 0 1", send_tx, tx_data, fifo_count, fifo_empty);
        end
        @(negedge clk);                                      // cycle N+3
        checks++;
        if (send_tx !== 1'b0 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_pulse_end: send=%b data=%h, want 0 a5", send_tx, tx_data);
        end
    endtask

    // busy rises 3 cycles after each launch, stays high 20 cycles.
    task automatic test_burst();
        int s = -1;
        int fall = -1;
        int nsend = 0;
        logic prev_busy = 1'b0;
        logic [7:0] exp_data [3] = '{8'h01, 8'h02, 8'h03};
        do_reset();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (send_tx === 1'b1) begin
                if (nsend < 3) begin
                    checks++;
                    if (tx_data !== exp_data[nsend]) begin
                        errors++;
                        $display("FAIL burst_data%0d: got %h want %h", nsend, tx_data, exp_data[nsend]);
                    end
                    if (nsend > 0) begin
                        checks++;
                        if (c != fall + 2) begin
                            errors++;
                            $display("FAIL burst_gap%0d: launch cycle %0d want %0d", nsend, c, fall + 2);
                        end
                    end
                end
                nsend++;
                s = c;
            end
            wr_en   = (c < 3);
            wr_data = 8'(c + 1);
            uart_busy = (s >= 0) && (c >= s + 3) && (c <= s + 22);
            if (prev_busy && !uart_busy) fall = c;
            prev_busy = uart_busy;
        end
        checks++;
        if (nsend != 3 || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL burst_count: launches %0d empty=%b want 3 1", nsend, fifo_empty);
        end
    endtask

    // Fill with busy held high, overflow, clear behaviour, then push during pop.
    task automatic test_full_overflow();
        logic [7:0] exp_q [$];
        int s = -100;
        int nsend = 0;
        do_reset();
        uart_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_data = 8'(8'h10 + i); exp_q.push_back(wr_data);
        end
        @(negedge clk); wr_en = 1'b0;
        checks++;
        if (fifo_full !== 1'b1 || fifo_count !== 4'd8 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_after8: full=%b cnt=%0d ovf=%b want 1 8 0", fifo_full, fifo_count, overflow);
        end
        wr_en = 1'b1; wr_data = 8'h18;                       // ninth push, dropped
        @(negedge clk); wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 4'd8) begin
            errors++;
            $display("FAIL overflow_set: ovf=%b cnt=%0d want 1 8", overflow, fifo_count);
        end
        wr_en = 1'b1; wr_data = 8'h19; clr_overflow = 1'b1;  // clear and drop together
        @(negedge clk); wr_en = 1'b0; clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_clr_race: ovf=%b want 1", overflow);
        end
        clr_overflow = 1'b1;
        @(negedge clk); clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0 || fifo_count !== 4'd8 || fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL overflow_clr: ovf=%b cnt=%0d full=%b want 0 8 1", overflow, fifo_count, fifo_full);
        end
        // Busy falls and a push lands in the IDLE->LAUNCH cycle.
        uart_busy = 1'b0; wr_en = 1'b1; wr_data = 8'h20; exp_q.push_back(8'h20);
        @(negedge clk); wr_en = 1'b0;
        checks++;
        if (send_tx !== 1'b1 || tx_data !== 8'h10 || fifo_count !== 4'd8 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL push_pop_full: send=%b data=%h cnt=%0d ovf=%b want 1 10 8 0", send_tx, tx_data, fifo_count, overflow);
        end
        void'(exp_q.pop_front());
        s = 0;
        // Drain remaining bytes with a short busy pulse per launch.
        for (int c = 1; c < 80; c++) begin
            uart_busy = (c >= s + 1) && (c <= s + 2);
            @(negedge clk);
            if (send_tx === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL drain_extra: unexpected launch data %h", tx_data);
                end else if (tx_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL drain_order: got %h want %h", tx_data, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                nsend++;
                s = c;
            end
        end
        uart_busy = 1'b0;
        checks++;
        if (nsend != 8 || fifo_count !== 4'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL drain_done: launches %0d cnt=%0d ovf=%b want 8 0 0", nsend, fifo_count, overflow);
        end
    endtask

    task automatic test_timeout();
        int nsend = 0;
        int send_cyc [4];
        logic [7:0] send_dat [4];
        logic tmo18 = 1'b0;
        logic tmo19 = 1'b0;
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            if (send_tx === 1'b1) begin
                if (nsend < 4) begin send_cyc[nsend] = c; send_dat[nsend] = tx_data; end
                nsend++;
            end
            if (c == 18) tmo18 = timeout_err;
            if (c == 19) tmo19 = timeout_err;
            wr_en   = (c == 0) || (c == 5);
            wr_data = (c == 0) ? 8'h55 : 8'h66;
        end
        wr_en = 1'b0;
        checks++;
        if (nsend < 1 || send_cyc[0] != 2 || send_dat[0] !== 8'h55) begin
            errors++;
            $display("FAIL tmo_first_launch: launches %0d, want first at cycle 2 with 55", nsend);
        end
`ifdef UART_TX_FIFO_TIMEOUT_EN
        checks++;
        if (tmo18 !== 1'b0 || tmo19 !== 1'b1) begin
            errors++;
            $display("FAIL tmo_flag: c18=%b c19=%b want 0 1", tmo18, tmo19);
        end
        checks++;
        if (nsend != 2 || send_cyc[1] != 20 || send_dat[1] !== 8'h66) begin
            errors++;
            $display("FAIL tmo_relaunch: launches %0d, want 2 with second at cycle 20 data 66", nsend);
        end
`else
        checks++;
        if (tmo18 !== 1'b0 || tmo19 !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_disabled_flag: c18=%b c19=%b end=%b want 0 0 0", tmo18, tmo19, timeout_err);
        end
        checks++;
        if (nsend != 1 || fifo_count !== 4'd1) begin
            errors++;
            $display("FAIL tmo_disabled_stall: launches %0d cnt=%0d want 1 1", nsend, fifo_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int extra = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            wr_en     = (c < 5);
            wr_data   = 8'(8'hA0 + c);
            uart_busy = (c >= 3);
        end
        wr_en = 1'b0;
        checks++;
        if (fifo_count !== 4'd4 || send_tx !== 1'b0) begin
            errors++;
            $display("FAIL mid_queued: cnt=%0d send=%b want 4 0", fifo_count, send_tx);
        end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        checks++;
        if (fifo_count !== 4'd0 || fifo_empty !== 1'b1 || send_tx !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: cnt=%0d empty=%b send=%b data=%h want 0 1 0 00", fifo_count, fifo_empty, send_tx, tx_data);
        end
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (send_tx === 1'b1) extra++;
            uart_busy = (c < 3);
        end
        checks++;
        if (extra != 0 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL mid_no_launch: launches %0d cnt=%0d want 0 0", extra, fifo_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_full_overflow();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
